// File: rtl/ring_monitor_pkg.sv
// rtl/ring_monitor_pkg.sv - shared types and helpers for the ring monitor
package ring_pkg;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_e;

  localparam int DEF_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  // Rotate toward the MSB within the low w bits; x must already fit in w bits.
  function automatic logic [63:0] rotl(input logic [63:0] x, input int w);
    logic [63:0] m;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x << 1) | (x >> (w - 1))) & m;
  endfunction

  function automatic logic is_onehot(input logic [63:0] x);
    return (x != 64'd0) && ((x & (x - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/ring_monitor_if.sv
// rtl/ring_monitor_if.sv - sample input and status outputs of the ring monitor
interface ring_monitor_if #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
);
  import ring_pkg::*;
  localparam int PW = clog2(WIDTH);

  logic             CE;
  logic [WIDTH-1:0] I;
  logic [PW-1:0]    phase;
  logic             locked;
  logic             error;
  logic [ERR_W-1:0] err_count;

  modport master (output CE, I, input phase, locked, error, err_count);
  modport slave  (input CE, I, output phase, locked, error, err_count);
endinterface

// File: rtl/ring_monitor_onehot_encode.sv
// rtl/ring_monitor_onehot_encode.sv - one-hot to bit-index encoder with validity flag
module onehot_encode
  import ring_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = 3
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [PW-1:0]    idx_o,
  output logic             valid_o
);

  always_comb begin
    idx_o = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (data_i[b]) idx_o = PW'(b);
    end
  end

  assign valid_o = is_onehot(64'(data_i));

endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - checks a rotating one-hot ring word, tracks phase, lock and lock losses
module ring_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  ring_monitor_if.slave    bus
);

  localparam int PW = clog2(WIDTH);

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             pv_q, pv_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic             error_q, error_d;
  logic [ERR_W-1:0] errc_q, errc_d;

  logic [PW-1:0]    enc_idx;
  logic             onehot;
  logic             match;
  logic [4:0]       run_inc;

  onehot_encode #(.WIDTH(WIDTH), .PW(PW)) u_enc (
    .data_i  (bus.I),
    .idx_o   (enc_idx),
    .valid_o (onehot)
  );

  assign match   = pv_q && onehot && (64'(bus.I) == rotl(64'(prev_q), WIDTH));
  assign run_inc = 5'(run_q) + 5'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= SEARCH;
      run_q   <= '0;
      prev_q  <= '0;
      pv_q    <= 1'b0;
      phase_q <= '0;
      error_q <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      pv_q    <= pv_d;
      phase_q <= phase_d;
      error_q <= error_d;
      errc_q  <= errc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    prev_d  = prev_q;
    pv_d    = pv_q;
    phase_d = phase_q;
    error_d = 1'b0;
    errc_d  = errc_q;
    if (bus.CE) begin
      prev_d = bus.I;
      pv_d   = onehot;
      if (onehot) phase_d = enc_idx;
      case (state_q)
        SEARCH: begin
          // A failed sample restarts the chain; it may itself seed the next match.
          if (!match) begin
            run_d = '0;
          end else if (run_inc == 5'(LOCK_COUNT)) begin
            state_d = LOCKED;
            run_d   = '0;
          end else begin
            run_d = run_inc[3:0];
          end
        end
        LOCKED: begin
          if (!match) begin
            state_d = SEARCH;
            run_d   = '0;
            error_d = 1'b1;
            if (errc_q != '1) errc_d = errc_q + ERR_W'(1);
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  assign bus.phase     = phase_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.error     = error_q;
  assign bus.err_count = errc_q;

endmodule
